// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: debounced 4-button N-digit BCD/hex up/down counter on a scanned 7-segment display
// Ports: i_button {mode,clear,dec,inc} raw presses; o_digitalTube {g..a} and o_sel one-hot digit scan;
// o_led mirrors counter[7:0]; o_wrap pulses for one cycle when the counter wraps max<->0.
module seg7_scan_counter #(
  parameter int N_DIGITS = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_button,
  output logic [6:0]          o_digitalTube,
  output logic [N_DIGITS-1:0] o_sel,
  output logic [7:0]          o_led,
  output logic                o_wrap
);
  localparam int W = 4 * N_DIGITS;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [W-1:0] DEC_MAX = {N_DIGITS{4'h9}};
  function automatic logic [6:0] seg_of(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    s = blank ? 7'h00 : s;
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction
  logic [3:0] s1, s2, lvl, pulse;
  logic [DW-1:0] dcnt [4];
  // A button level is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
  // only accepted presses (0->1) generate a command pulse.
  always_ff @(posedge i_clk)
    if (i_rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      pulse <= '0;
      for (int b = 0; b < 4; b++) dcnt[b] <= '0;
    end else begin
      s1 <= i_button;
      s2 <= s1;
      for (int b = 0; b < 4; b++) begin
        pulse[b] <= 1'b0;
        if (s2[b] == lvl[b]) dcnt[b] <= '0;
        else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[b] <= '0;
          lvl[b] <= s2[b];
          pulse[b] <= s2[b];
        end else dcnt[b] <= dcnt[b] + 1'b1;
      end
    end
  logic inc, dec, clr, mode_t;
  assign {mode_t, clr, dec, inc} = pulse;
  logic hex, wrap_n, ci, cd, z, term, dig_blank;
  logic [W-1:0] cnt, cnt_inc, cnt_dec, cnt_n, cnt_max;
  logic [N_DIGITS-1:0] blank, sel_n;
  logic [SW-1:0] scan;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] dig;
  always_comb begin
    cnt_inc = cnt + 1'b1;
    cnt_dec = cnt - 1'b1;
    ci = 1'b1;
    cd = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!hex) begin
        cnt_inc[4*k +: 4] = ci ? (cnt[4*k +: 4] == 4'd9 ? 4'd0 : cnt[4*k +: 4] + 4'd1) : cnt[4*k +: 4];
        cnt_dec[4*k +: 4] = cd ? (cnt[4*k +: 4] == 4'd0 ? 4'd9 : cnt[4*k +: 4] - 4'd1) : cnt[4*k +: 4];
      end
      ci = ci & (cnt[4*k +: 4] == 4'd9);
      cd = cd & (cnt[4*k +: 4] == 4'd0);
    end
    cnt_max = hex ? '1 : DEC_MAX;
    cnt_n = cnt;
    wrap_n = 1'b0;
    // mode always forces zero, so clear and mode share the counter path
    if (clr | mode_t) cnt_n = '0;
    else if (inc ^ dec) begin
      cnt_n = inc ? cnt_inc : cnt_dec;
      wrap_n = inc ? cnt == cnt_max : cnt == '0;
    end
    z = 1'b1;
    blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      z = z & (cnt[4*k +: 4] == 4'd0);
      blank[k] = z && (k != 0);
    end
    term = scan == SW'(SCAN_CYCLES - 1);
    idx_n = term ? (idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
    dig = '0;
    dig_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++)
      if (idx_n == IW'(k)) begin
        dig = cnt[4*k +: 4];
        dig_blank = blank[k];
      end
    sel_n = N_DIGITS'(1) << idx_n;
    sel_n = SEG_ACTIVE_LOW ? ~sel_n : sel_n;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      cnt <= '0;
      hex <= 1'b0;
      o_led <= '0;
      o_wrap <= 1'b0;
      scan <= '0;
      idx <= '0;
      o_sel <= SEG_ACTIVE_LOW ? ~N_DIGITS'(1) : N_DIGITS'(1);
      o_digitalTube <= seg_of(4'h0, 1'b0);
    end else begin
      cnt <= cnt_n;
      hex <= hex ^ mode_t;
      o_led <= 8'(cnt_n);
      o_wrap <= wrap_n;
      scan <= term ? '0 : scan + 1'b1;
      idx <= idx_n;
      // the digit pattern is latched at selection time, so counter changes show on the next visit
      if (term) begin
        o_sel <= sel_n;
        o_digitalTube <= seg_of(dig, dig_blank);
      end
    end
endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb_seg7_scan_counter: directed scoreboard bench for seg7_scan_counter (N=2, debounce 4, scan 3, active-low)
module tb_seg7_scan_counter;
  localparam int D = 4;
  localparam int S = 3;
  localparam logic [6:0] SEG_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn = 4'h0;
  logic [6:0] tube;
  logic [1:0] sel;
  logic [7:0] led;
  logic wrap;
  int vectors = 0;
  int miscompares = 0;
  int val = 0;
  bit hexm = 1'b0;
  typedef struct {
    string tag;
    logic [7:0] led;
    logic wrap;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  seg7_scan_counter #(.N_DIGITS(2), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_button(btn), .o_digitalTube(tube), .o_sel(sel), .o_led(led), .o_wrap(wrap)
  );
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] led_of();
    return hexm ? 8'(val) : 8'((val / 10) * 16 + val % 10);
  endfunction
  function automatic logic [6:0] seg_exp(input logic [3:0] n, input bit blank);
    return blank ? 7'h7F : ~SEG_HI[n];
  endfunction
  task automatic press(input logic [3:0] b, input logic [7:0] prev, input logic [7:0] e_led,
                       input bit e_wrap, input string tag);
    exp_t e;
    int wraps;
    q.push_back('{tag, e_led, e_wrap});
    wraps = 0;
    @(negedge clk);
    btn = b;
    repeat (D + 2) begin
      @(posedge clk); #1;
      wraps += int'(wrap);
    end
    chk({tag, " early"}, led, prev);
    @(posedge clk); #1;
    wraps += int'(wrap);
    e = q.pop_front();
    chk({e.tag, " led"}, led, e.led);
    chk({e.tag, " wrap"}, wrap, e.wrap);
    @(negedge clk);
    btn = 4'h0;
    repeat (D + 5) begin
      @(posedge clk); #1;
      wraps += int'(wrap);
    end
    chk({e.tag, " wrapcnt"}, wraps, e.wrap);
  endtask
  task automatic apply(input logic [3:0] b, input string tag);
    logic [7:0] prev;
    bit w;
    int mx;
    prev = led_of();
    mx = hexm ? 255 : 99;
    w = 1'b0;
    if (b[2] | b[3]) begin
      val = 0;
      hexm ^= b[3];
    end else if (b[0] ^ b[1]) begin
      w = b[0] ? val == mx : val == 0;
      val = b[0] ? (val == mx ? 0 : val + 1) : (val == 0 ? mx : val - 1);
    end
    press(b, prev, led_of(), w, tag);
  endtask
  task automatic disp_check(input string tag);
    logic [7:0] l;
    l = led_of();
    repeat (2 * S + 2) begin
      @(posedge clk); #1;
      chk({tag, " sel"}, sel == 2'b10 || sel == 2'b01, 1);
      chk({tag, " seg"}, tube, sel == 2'b01 ? seg_exp(l[7:4], l[7:4] == 4'h0) : seg_exp(l[3:0], 1'b0));
    end
  endtask
  initial begin
    int wraps;
    bit found;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst sel", sel, 2'b10);
    chk("rst seg", tube, 7'h40);
    chk("rst led", led, 8'h00);
    chk("rst wrap", wrap, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("scan sel", sel, ((k / 3) % 2) != 0 ? 2'b01 : 2'b10);
      chk("scan seg", tube, ((k / 3) % 2) != 0 ? 7'h7F : 7'h40);
    end
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 2 == 0) btn[0] = ~btn[0];
      wraps += int'(wrap);
    end
    @(negedge clk);
    btn[0] = 1'b1;
    val = 1;
    q.push_back('{"glitch", led_of(), 1'b0});
    repeat (10) begin
      @(posedge clk); #1;
      wraps += int'(wrap);
    end
    e = q.pop_front();
    chk({e.tag, " led"}, led, e.led);
    @(negedge clk);
    btn = 4'h0;
    repeat (D + 5) begin
      @(posedge clk); #1;
      wraps += int'(wrap);
    end
    chk("glitch wrapcnt", wraps, 0);
    apply(4'b0001, "inc2");
    repeat (97) apply(4'b0001, "inc_to_99");
    disp_check("dec99");
    apply(4'b0001, "dec_wrap_up");
    apply(4'b0010, "dec_wrap_down");
    apply(4'b0100, "clear");
    repeat (37) apply(4'b0001, "inc_to_37");
    apply(4'b1000, "mode_hex");
    repeat (26) apply(4'b0001, "hex_inc");
    disp_check("hex1A");
    apply(4'b0100, "hex_clear");
    apply(4'b0010, "hex_wrap_down");
    apply(4'b0001, "hex_wrap_up");
    apply(4'b0011, "incdec_at0");
    repeat (3) apply(4'b0001, "hex_inc3");
    apply(4'b0011, "incdec_at3");
    apply(4'b0101, "clear_inc");
    repeat (5) apply(4'b0001, "hex_inc5");
    apply(4'b1100, "mode_clear");
    repeat (5) apply(4'b0001, "dec_inc5");
    disp_check("dec05");
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      found = sel == 2'b01;
    end
    chk("sel1 wait", found, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2 sel", sel, 2'b10);
    chk("rst2 seg", tube, 7'h40);
    chk("rst2 led", led, 8'h00);
    chk("rst2 wrap", wrap, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    val = 0;
    hexm = 1'b0;
    apply(4'b0010, "rst2_dec_mode");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
Parametrised successor to the single-digit button/tube/LED demo. Debounces four raw buttons internally and drives an N-digit up/down counter with decimal and hex modes. Output is a time-multiplexed N-digit 7-segment display with leading-zero blanking, plus an LED mirror and a wrap flag. It sits directly under the board top and replaces the separate button, tube and LED drivers.

Parameters:
N_DIGITS, 4, number of display digits; valid range 1..8; the counter holds N_DIGITS x 4 bits.
DEBOUNCE_CYCLES, 1000000, number of consecutive equal synchronised samples needed to accept a new button level; minimum 2.
SCAN_CYCLES, 50000, number of clocks each digit stays selected; minimum 1.
SEG_ACTIVE_LOW, 1, when 1 both o_digitalTube and o_sel are inverted (common-anode board).

Ports:
i_clk  in  1  single system clock.
i_rst  in  1  synchronous, active-high reset.
i_button  in  4  raw buttons, 1 = pressed; [0] increment, [1] decrement, [2] clear, [3] mode toggle.
o_digitalTube  out  7  segments {g,f,e,d,c,b,a}, registered.
o_sel  out  N_DIGITS  one-hot digit select, registered; bit 0 is the least significant digit.
o_led  out  8  low 8 bits of the counter.
o_wrap  out  1  one-cycle pulse on counter wrap-around.

Behaviour:
- Reset (i_rst sampled high at a clock edge), next cycle:
  - counter = 0, mode = decimal, digit index = 0, scan and debounce counters = 0, debounced levels = 0.
  - o_led = 0, o_wrap = 0.
  - o_sel selects digit 0 (N=4, active-low: 4'b1110).
  - o_digitalTube shows "0" (active-low: 7'h40).
  - Reset mid-scan or mid-debounce discards all in-flight state.
- Debounce, per button:
  - 2-flop synchroniser feeds a stability counter.
  - When the synchronised level differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles, the accepted level updates; any match in between clears the counter.
  - An accepted 0->1 transition produces a one-cycle internal pulse. Release produces nothing.
  - Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- Command resolution, applied in the pulse cycle with the result visible next cycle; priority clear > mode > inc/dec:
  - clear: counter = 0.
  - mode: toggle decimal/hex and force counter = 0.
  - inc and dec in the same cycle: no change.
  - inc: decimal is BCD +1 with per-digit carry; max is all digits 9. Hex is binary +1; max is all digits F. From max the counter goes to 0.
  - dec: inverse of inc. From 0 the counter goes to max.
  - o_wrap pulses high for one cycle, coincident with the counter update, only on max->0 (inc) or 0->max (dec).
- Scan:
  - Scan counter counts 0..SCAN_CYCLES-1. On terminal count, digit index advances (N_DIGITS-1 wraps to 0).
  - o_sel and o_digitalTube are registered together and change in the same cycle.
  - The displayed value is the counter's current content, so updates appear at the digit's next selection.
- Decode, active-high form (invert when SEG_ACTIVE_LOW):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Blank = 00.
- Leading-zero blanking: digit k > 0 is blank when digits k..N_DIGITS-1 are all zero. Digit 0 is never blanked.
- o_led = counter[7:0] (raw BCD or hex nibbles), registered alongside the counter. Upper bits are 0 when N_DIGITS = 1.

Test Plan:
All scenarios use N_DIGITS=2, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, SEG_ACTIVE_LOW=1.
1. Reset -> o_sel=2'b10, o_digitalTube=7'h40, o_led=8'h00, o_wrap=0. Hold 12 cycles: o_sel alternates every 3 cycles, with digit 1 blank (7'h7F).
2. i_button[0] toggles every 2 cycles for 20 cycles, then is held high 10 cycles -> exactly one increment; o_led=8'h01. Release and repress cleanly -> o_led=8'h02.
3. Decimal wrap: 99 clean increments -> o_led=8'h99, digits show 9/9 (7'h10). One more -> o_led=8'h00 with o_wrap high exactly 1 cycle. Decrement from 00 -> 8'h99 with an o_wrap pulse.
4. Mode toggle at count 8'h37 -> counter 00, hex mode. 26 increments -> o_led=8'h1A; digit 1 = 7'h79 ("1"), digit 0 = 7'h08 ("A"). 255 -> 256 wraps to 0x00 with o_wrap.
5. Simultaneous: inc+dec pulses in the same cycle -> counter unchanged, no o_wrap. clear+inc -> 0. mode+clear at hex 0x05 -> counter 0, mode toggled to decimal.
6. Count 5 decimal -> digit 1 = 7'h7F (blank), digit 0 = 7'h12. Assert i_rst while digit 1 is selected and count=5 -> next cycle o_sel=2'b10, o_digitalTube=7'h40, o_led=0, mode decimal.
